// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Front-panel control block. It debounces an active-low push button and then
//   either pushes the switch word into the operand FIFO (write mode) or pops
//   one instruction, decodes it, runs it on the sign-magnitude ALU and latches
//   the operands and result into the display/LED registers (read mode).
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   button, mode, dataIn   front panel: active-low button, 1=write/0=read,
//                          switch word {op[2:0], a_sign, a_mag, b_sign, b_mag}
//   fifo_*                 operand FIFO handshake (rdata valid the cycle after pop)
//   alu_*                  ALU issue (start pulse, op, operands) and completion
//   disp_*                 display / LED registers, updated only on completion
//   busy                   high while a press is being serviced
//   err_ovf/udf/op/to      sticky: push on full, pop on empty, illegal op, ALU timeout
module alu_op_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter int unsigned MAG_W           = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button,
  input  logic               mode,
  input  logic [2*MAG_W+4:0] dataIn,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  input  logic [2*MAG_W+4:0] fifo_rdata,
  output logic               fifo_push,
  output logic [2*MAG_W+4:0] fifo_wdata,
  output logic               fifo_pop,
  output logic               alu_start,
  output logic [2:0]         alu_op,
  output logic               alu_a_sign,
  output logic               alu_b_sign,
  output logic [MAG_W-1:0]   alu_a_mag,
  output logic [MAG_W-1:0]   alu_b_mag,
  input  logic               alu_done,
  input  logic               alu_c_sign,
  input  logic [MAG_W-1:0]   alu_c_mag,
  input  logic               alu_of,
  output logic [MAG_W-1:0]   disp_a_mag,
  output logic [MAG_W-1:0]   disp_b_mag,
  output logic [MAG_W-1:0]   disp_c_mag,
  output logic               disp_a_sign,
  output logic               disp_b_sign,
  output logic               disp_c_sign,
  output logic               disp_of,
  output logic               busy,
  output logic               err_ovf,
  output logic               err_udf,
  output logic               err_op,
  output logic               err_to
);

  localparam int unsigned INSTR_W = 2*MAG_W + 5;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_POP, S_DECODE, S_EXEC, S_WAIT, S_LATCH
  } state_e;

  state_e             state_q, state_d;
  logic               db_pressed_q, db_pressed_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [TO_W-1:0]    tmo_q, tmo_d;
  logic [MAG_W:0]     disp_a_q, disp_a_d, disp_b_q, disp_b_d, disp_c_q, disp_c_d;
  logic               disp_of_q, disp_of_d;
  logic               err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
  logic               err_op_q, err_op_d, err_to_q, err_to_d;
  logic               press_evt;
  logic               cmp_op;

  // Debouncer: accepted level moves only after DEBOUNCE_CYCLES consecutive
  // samples that disagree with it; any agreeing sample restarts the count.
  always_comb begin
    db_pressed_d = db_pressed_q;
    db_cnt_d     = '0;
    press_evt    = 1'b0;
    if (~button != db_pressed_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_pressed_d = ~button;
        press_evt    = ~button;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign cmp_op = instr_q[INSTR_W-1];

  always_comb begin
    state_d   = state_q;
    wdata_d   = wdata_q;
    instr_d   = instr_q;
    tmo_d     = tmo_q;
    disp_a_d  = disp_a_q;
    disp_b_d  = disp_b_q;
    disp_c_d  = disp_c_q;
    disp_of_d = disp_of_q;
    err_ovf_d = err_ovf_q;
    err_udf_d = err_udf_q;
    err_op_d  = err_op_q;
    err_to_d  = err_to_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    alu_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_evt) begin
          if (mode) begin
            wdata_d = dataIn;
            state_d = S_PUSH;
          end else begin
            state_d = S_POP;
          end
        end
      end
      S_PUSH: begin
        if (fifo_full) err_ovf_d = 1'b1;
        else           fifo_push = 1'b1;
        state_d = S_IDLE;
      end
      S_POP: begin
        if (fifo_empty) begin
          err_udf_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          fifo_pop = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        instr_d = fifo_rdata;
        if (fifo_rdata[INSTR_W-1 -: 2] == 2'b01) begin
          err_op_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_start = 1'b1;
        // Counter holds cycles elapsed since alu_start, so the abort lands
        // with err_to visible exactly TIMEOUT_CYCLES after the start pulse.
        tmo_d     = TO_W'(1);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          state_d = S_LATCH;
        end else if (tmo_q >= TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_LATCH: begin
        disp_a_d  = instr_q[2*MAG_W+1 -: MAG_W+1];
        disp_b_d  = instr_q[MAG_W:0];
        // Compare/zero ops produce an unsigned 0/1 result with no overflow.
        disp_c_d  = {alu_c_sign & ~cmp_op, alu_c_mag};
        disp_of_d = alu_of & ~cmp_op;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      db_pressed_q <= 1'b0;
      db_cnt_q     <= '0;
      wdata_q      <= '0;
      instr_q      <= '0;
      tmo_q        <= '0;
      disp_a_q     <= '0;
      disp_b_q     <= '0;
      disp_c_q     <= '0;
      disp_of_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_udf_q    <= 1'b0;
      err_op_q     <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_pressed_q <= db_pressed_d;
      db_cnt_q     <= db_cnt_d;
      wdata_q      <= wdata_d;
      instr_q      <= instr_d;
      tmo_q        <= tmo_d;
      disp_a_q     <= disp_a_d;
      disp_b_q     <= disp_b_d;
      disp_c_q     <= disp_c_d;
      disp_of_q    <= disp_of_d;
      err_ovf_q    <= err_ovf_d;
      err_udf_q    <= err_udf_d;
      err_op_q     <= err_op_d;
      err_to_q     <= err_to_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign fifo_wdata  = wdata_q;
  assign alu_op      = instr_q[INSTR_W-1 -: 3];
  assign alu_a_sign  = instr_q[2*MAG_W+1];
  assign alu_a_mag   = instr_q[2*MAG_W -: MAG_W];
  assign alu_b_sign  = instr_q[MAG_W];
  assign alu_b_mag   = instr_q[MAG_W-1:0];
  assign disp_a_sign = disp_a_q[MAG_W];
  assign disp_a_mag  = disp_a_q[MAG_W-1:0];
  assign disp_b_sign = disp_b_q[MAG_W];
  assign disp_b_mag  = disp_b_q[MAG_W-1:0];
  assign disp_c_sign = disp_c_q[MAG_W];
  assign disp_c_mag  = disp_c_q[MAG_W-1:0];
  assign disp_of     = disp_of_q;
  assign err_ovf     = err_ovf_q;
  assign err_udf     = err_udf_q;
  assign err_op      = err_op_q;
  assign err_to      = err_to_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Randomized self-checking bench for alu_op_sequencer. Each press is driven
//   with a small FIFO/ALU environment, and the expected strobes, timing,
//   sticky errors and display contents come from a transaction-level model.
module tb_alu_op_sequencer;

  localparam int DB = 4;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset, button, mode;
  logic [14:0] dataIn, fifo_rdata, fifo_wdata;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic        alu_start, alu_a_sign, alu_b_sign, alu_done, alu_c_sign, alu_of;
  logic [2:0]  alu_op;
  logic [4:0]  alu_a_mag, alu_b_mag, alu_c_mag;
  logic [4:0]  disp_a_mag, disp_b_mag, disp_c_mag;
  logic        disp_a_sign, disp_b_sign, disp_c_sign, disp_of;
  logic        busy, err_ovf, err_udf, err_op, err_to;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  exp_err;   // {ovf, udf, op, to}
  logic [18:0] exp_disp;  // {a_s, a_m, b_s, b_m, c_s, c_m, of}

  alu_op_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .MAG_W          (5)
  ) dut (
    .clk(clk), .reset(reset), .button(button), .mode(mode), .dataIn(dataIn),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_push(fifo_push), .fifo_wdata(fifo_wdata), .fifo_pop(fifo_pop),
    .alu_start(alu_start), .alu_op(alu_op),
    .alu_a_sign(alu_a_sign), .alu_b_sign(alu_b_sign),
    .alu_a_mag(alu_a_mag), .alu_b_mag(alu_b_mag),
    .alu_done(alu_done), .alu_c_sign(alu_c_sign), .alu_c_mag(alu_c_mag), .alu_of(alu_of),
    .disp_a_mag(disp_a_mag), .disp_b_mag(disp_b_mag), .disp_c_mag(disp_c_mag),
    .disp_a_sign(disp_a_sign), .disp_b_sign(disp_b_sign), .disp_c_sign(disp_c_sign),
    .disp_of(disp_of), .busy(busy),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_op(err_op), .err_to(err_to)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] disp_now();
    return {disp_a_sign, disp_a_mag, disp_b_sign, disp_b_mag, disp_c_sign, disp_c_mag, disp_of};
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({fifo_push, fifo_wdata, fifo_pop, alu_start, alu_op, alu_a_sign, alu_a_mag,
                alu_b_sign, alu_b_mag, disp_now(), busy, err_ovf, err_udf, err_op, err_to});
  endfunction

  task automatic do_reset();
    reset = 1'b1; button = 1'b1; alu_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_err = '0; exp_disp = '0;
  endtask

  // Short or bouncing low levels must never be accepted as a press.
  task automatic glitch_check(input int n1, input int gap, input int n2, input string tag);
    int busy_seen = 0;
    int pushes = 0;
    mode = 1'b1; fifo_full = 1'b0; dataIn = 15'h1234;
    button = 1'b0;
    for (int k = 1; k <= n1 + gap + n2 + 8; k++) begin
      tick();
      if (busy) busy_seen++;
      if (fifo_push) pushes++;
      button = (k < n1 || (k >= n1 + gap && k < n1 + gap + n2)) ? 1'b0 : 1'b1;
    end
    check_eq({tag, "_busy"}, busy_seen, 0);
    check_eq({tag, "_push"}, pushes, 0);
  endtask

  // One press. lat = ALU done latency in cycles after alu_start (0 = never).
  task automatic run_op(input logic m, input logic [14:0] data, input logic full,
                        input logic empty, input logic [14:0] rdata, input int lat,
                        input int hold, input logic stray);
    logic [2:0]  op;
    logic        cs, cof, prev_to, illegal;
    logic [4:0]  cm;
    int          av, bv, r, ar;
    int          exp_busy, exp_push, exp_pop, exp_start, window, cd;
    int          busy_cnt, busy_first, push_cnt, pop_cnt, pop_tick, start_cnt, start_tick;
    int          both, to_tick;
    logic [14:0] push_data, fields;
    logic        last_to;

    op = rdata[14:12];
    illegal = (op == 3'd2 || op == 3'd3);
    prev_to = exp_err[0];
    av = rdata[11] ? -int'(rdata[10:6]) : int'(rdata[10:6]);
    bv = rdata[5]  ? -int'(rdata[4:0])  : int'(rdata[4:0]);
    if (op[2]) begin
      cm = 5'($urandom_range(0, 1)); cs = 1'($urandom); cof = 1'($urandom);
    end else begin
      r   = (op == 3'd0) ? av + bv : av - bv;
      ar  = (r < 0) ? -r : r;
      cs  = (r < 0);
      cm  = 5'(ar);
      cof = (ar > 31);
    end

    exp_push = 0; exp_pop = 0; exp_start = 0; window = 12;
    if (m) begin
      exp_busy = 1;
      if (full) exp_err[3] = 1'b1; else exp_push = 1;
    end else if (empty) begin
      exp_busy = 1; exp_err[2] = 1'b1;
    end else if (illegal) begin
      exp_busy = 2; exp_pop = 1; exp_err[1] = 1'b1;
    end else begin
      exp_pop = 1; exp_start = 1;
      if (lat == 0) begin
        exp_busy = 2 + TO; exp_err[0] = 1'b1; window = TO + 16;
      end else begin
        exp_busy = lat + 4; window = lat + 10;
        exp_disp = {rdata[11:0], op[2] ? 1'b0 : cs, cm, op[2] ? 1'b0 : cof};
      end
    end

    busy_cnt = 0; busy_first = 0; push_cnt = 0; pop_cnt = 0; pop_tick = 0;
    start_cnt = 0; start_tick = 0; both = 0; to_tick = 0; cd = 0;
    push_data = '0; fields = '0; last_to = err_to;
    mode = m; dataIn = data; fifo_full = full; fifo_empty = empty; fifo_rdata = rdata;
    button = 1'b0;
    for (int k = 1; k <= window + 6; k++) begin
      tick();
      if (busy) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = k;
      end
      if (fifo_push) begin push_cnt++; push_data = fifo_wdata; end
      if (fifo_pop) begin pop_cnt++; pop_tick = k; end
      if (fifo_push && fifo_pop) both++;
      if (err_to && !last_to) to_tick = k;
      last_to = err_to;
      button = (k < hold) ? 1'b0 : 1'b1;
      alu_done = 1'b0;
      if (alu_start) begin
        start_cnt++; start_tick = k;
        fields = {alu_op, alu_a_sign, alu_a_mag, alu_b_sign, alu_b_mag};
        cd = lat;
        alu_c_sign = cs; alu_c_mag = cm; alu_of = cof;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) alu_done = 1'b1;
      end
      if (stray && k == window + 2) alu_done = 1'b1;
    end
    alu_done = 1'b0;

    check_eq("press_latency", busy_first, 4);
    check_eq("busy_len", busy_cnt, exp_busy);
    check_eq("push_cnt", push_cnt, exp_push);
    if (exp_push != 0) check_eq("push_wdata", push_data, data);
    check_eq("pop_cnt", pop_cnt, exp_pop);
    if (exp_pop != 0) check_eq("pop_tick", pop_tick, 4);
    check_eq("start_cnt", start_cnt, exp_start);
    if (exp_start != 0) begin
      check_eq("start_tick", start_tick, 6);
      check_eq("alu_fields", fields, rdata);
    end
    check_eq("push_pop_overlap", both, 0);
    if (exp_start != 0 && lat == 0 && !prev_to) check_eq("timeout_tick", to_tick, 6 + TO);
    check_eq("errors", {err_ovf, err_udf, err_op, err_to}, exp_err);
    check_eq("display", disp_now(), exp_disp);
  endtask

  initial begin
    int found;
    reset = 1'b1; button = 1'b1; mode = 1'b0; dataIn = '0;
    fifo_full = 1'b0; fifo_empty = 1'b0; fifo_rdata = '0;
    alu_done = 1'b0; alu_c_sign = 1'b0; alu_c_mag = '0; alu_of = 1'b0;
    exp_err = '0; exp_disp = '0;
    do_reset();
    check_eq("reset_state", all_outs(), 64'd0);

    glitch_check(3, 0, 0, "short_press");
    glitch_check(3, 1, 3, "bounce");
    glitch_check(2, 1, 2, "bounce2");

    run_op(1'b1, 15'd323,  1'b0, 1'b0, 15'd0,    0, 5, 1'b0);
    run_op(1'b1, 15'd323,  1'b0, 1'b0, 15'd0,    0, 6, 1'b0);
    run_op(1'b0, 15'd0,    1'b0, 1'b0, 15'd323,  2, 6, 1'b0);
    run_op(1'b0, 15'd0,    1'b0, 1'b0, 15'd4293, 2, 6, 1'b1);
    run_op(1'b1, 15'd77,   1'b1, 1'b0, 15'd0,    0, 6, 1'b0);
    run_op(1'b0, 15'd0,    1'b0, 1'b1, 15'd323,  2, 6, 1'b0);
    run_op(1'b0, 15'd0,    1'b0, 1'b0, 15'd8192, 2, 6, 1'b0);

    do_reset();
    run_op(1'b0, 15'd0, 1'b0, 1'b0, 15'd323, 0, 6, 1'b0);

    // Reset while waiting on the ALU, then a late done pulse.
    do_reset();
    mode = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0; fifo_rdata = 15'd323;
    button = 1'b0; found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      tick();
      if (alu_start) found = k;
      button = (k < 4) ? 1'b0 : 1'b1;
    end
    check_eq("rst_wait_start", found, 6);
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    check_eq("rst_in_wait", all_outs(), 64'd0);
    reset = 1'b0; alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check_eq("late_done", all_outs(), 64'd0);
    exp_err = '0; exp_disp = '0;

    for (int i = 0; i < 30; i++) begin
      run_op(1'($urandom), 15'($urandom), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), 15'($urandom), int'($urandom_range(1, 6)),
             int'($urandom_range(4, 10)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control block between the front-panel inputs (push button, mode switch, 15-bit data switches), the operand FIFO and the sign-magnitude ALU datapath.
- Write mode: each debounced button press pushes the switch word into the FIFO.
- Read mode: each press pops one instruction word, decodes it, issues it to the ALU and waits for completion. The operands and result are then latched into the display registers that drive the seven-segment and sign/overflow LEDs.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button level change
TIMEOUT_CYCLES, 64, max cycles from alu_start to alu_done before abort
MAG_W, 5, operand/result magnitude width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
button  in  1  push button, active-low (0 = pressed)
mode  in  1  1 = write (push), 0 = read (execute)
dataIn  in  15  switch word: [14:12] op, [11] A sign, [10:6] A mag, [5] B sign, [4:0] B mag
fifo_full  in  1  FIFO full
fifo_empty  in  1  FIFO empty
fifo_rdata  in  15  FIFO read data, valid the cycle after fifo_pop
fifo_push  out  1  one-cycle push strobe
fifo_wdata  out  15  push data
fifo_pop  out  1  one-cycle pop strobe
alu_start  out  1  one-cycle operation start
alu_op  out  3  opcode to ALU
alu_a_sign, alu_b_sign  out  1 each  operand signs
alu_a_mag, alu_b_mag  out  MAG_W each  operand magnitudes
alu_done  in  1  one-cycle completion pulse
alu_c_sign  in  1  result sign
alu_c_mag  in  MAG_W  result magnitude (compare ops: 0/1)
alu_of  in  1  overflow
disp_a_mag, disp_b_mag, disp_c_mag  out  MAG_W each  display registers
disp_a_sign, disp_b_sign, disp_c_sign, disp_of  out  1 each  LED registers
busy  out  1  high from press acceptance to return to IDLE
err_ovf, err_udf, err_op, err_to  out  1 each  sticky: push-on-full, pop-on-empty, illegal op, ALU timeout

Behaviour:
- Reset (synchronous, highest priority, legal in any state):
  - FSM goes to IDLE.
  - All outputs are 0, including the display registers and sticky errors.
  - Debouncer state = released, counter = 0.
- Debouncer:
  - The button level must differ from the accepted level for DEBOUNCE_CYCLES consecutive cycles before the accepted level changes. Any bounce restarts the count.
  - A press_evt (internal) fires for one cycle when the accepted level goes released -> pressed.
  - No further press_evt until the button has been accepted as released.
- mode and dataIn are sampled on the press_evt cycle (T).
- press_evt while busy = 1 is discarded; no queuing.
- FSM states: IDLE, PUSH, POP, DECODE, EXEC, WAIT, LATCH.
- IDLE, on press_evt at T:
  - mode = 1 -> PUSH.
  - mode = 0 -> POP.
  - busy = 1 from T+1.
- PUSH (T+1):
  - fifo_full = 0: fifo_push = 1, fifo_wdata = sampled dataIn.
  - fifo_full = 1: no push, set err_ovf.
  - Next state IDLE in both cases.
- POP (T+1):
  - fifo_empty = 1: no pop, set err_udf, next state IDLE.
  - Otherwise fifo_pop = 1, next state DECODE.
- DECODE (T+2):
  - Capture fifo_rdata into the operand/op registers driving the alu_* outputs. These stay stable until the next DECODE.
  - op in {010, 011} -> set err_op, next state IDLE; displays unchanged.
  - Otherwise next state EXEC.
- EXEC (T+3): alu_start = 1 for one cycle; clear the timeout counter; next state WAIT.
- WAIT:
  - alu_done -> LATCH.
  - Timeout counter reaches TIMEOUT_CYCLES without alu_done -> set err_to, next state IDLE; displays unchanged.
  - alu_done in the same cycle as expiry counts as done.
- LATCH:
  - disp_a/b <= operand registers.
  - disp_c_mag/sign <= alu_c_mag/sign; disp_of <= alu_of.
  - For compare/zero ops (1xx), disp_c_sign <= 0 and disp_of <= 0.
  - Next state IDLE; busy falls the following cycle.
- alu_done outside WAIT is ignored.
- Sticky errors clear only on reset.
- fifo_push and fifo_pop are never asserted together and never for more than one cycle.

Test Plan:
- Reset held 2 cycles, then button low 3 cycles -> no press_evt, busy stays 0. Button low 5 cycles -> exactly one fifo_push.
- Write mode, dataIn = 323 (add, +5, +3), fifo_full = 0, button held low 6 cycles -> fifo_push pulse with fifo_wdata = 323, busy high 1 cycle, no second push while the button stays low.
- Read mode, fifo_rdata = 323; ALU model pulses alu_done 2 cycles after alu_start with C = +8, of = 0 -> alu_start at press+3, alu_a_mag = 5, alu_b_mag = 3, then disp_c_mag = 8, disp_c_sign = 0.
- Read mode, fifo_rdata = 4293 (sub, +3, +5); model returns C sign = 1, mag = 2 -> disp_c_sign = 1, disp_c_mag = 2, disp_a_mag = 3, disp_b_mag = 5.
- Press with fifo_full = 1 in write mode -> no push, err_ovf = 1. Press with fifo_empty = 1 in read mode -> no pop, err_udf = 1. fifo_rdata = 8192 (op 010) -> no alu_start, err_op = 1.
- ALU model never asserts alu_done -> err_to = 1 exactly TIMEOUT_CYCLES (64) after alu_start, FSM back in IDLE. Separately, reset asserted during WAIT -> IDLE next cycle, all outputs 0, and a late alu_done has no effect.
